// File: rtl/mem_stage_hs.sv
// MEM stage with req/ack DMEM handshake.
// Byte lanes, sign extension, misalign and timeout exceptions.
module mem_stage_hs #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int PC_WIDTH        = 12,
    parameter int INSTR_WIDTH     = 16,
    parameter int MAX_WAIT        = 15
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [2:0]                            in_op,
    input  logic [DMEM_ADDR_WIDTH-1:0]            in_addr,
    input  logic [DATA_WIDTH-1:0]                 in_wr_data,
    input  logic [DATA_WIDTH-1:0]                 in_res,
    input  logic [REG_IDX_WIDTH-1:0]              in_res_reg_idx,
    input  logic                                  in_write_res_to_reg,
    input  logic [PC_WIDTH-1:0]                   in_pc,
    input  logic [INSTR_WIDTH-1:0]                in_instr,
    output logic                                  out_stall,
    output logic                                  dmem_req,
    output logic                                  dmem_we,
    output logic [DMEM_ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0] dmem_addr,
    output logic [DATA_WIDTH/8-1:0]               dmem_be,
    output logic [DATA_WIDTH-1:0]                 dmem_wdata,
    input  logic                                  dmem_ack,
    input  logic [DATA_WIDTH-1:0]                 dmem_rdata,
    output logic                                  out_valid,
    output logic [DATA_WIDTH-1:0]                 out_res,
    output logic [REG_IDX_WIDTH-1:0]              out_res_reg_idx,
    output logic                                  out_write_res_to_reg,
    output logic [PC_WIDTH-1:0]                   out_pc,
    output logic [INSTR_WIDTH-1:0]                out_instr,
    output logic                                  out_exc_misaligned,
    output logic                                  out_exc_timeout
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int WADDR_W   = DMEM_ADDR_WIDTH - LANE_BITS;
    localparam int CNT_W     = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] OP_LW  = 3'b001;
    localparam logic [2:0] OP_LBS = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               op_q, op_d;
    logic [LANE_BITS-1:0]     lane_q, lane_d;
    logic [DATA_WIDTH-1:0]    res_q, res_d;
    logic [REG_IDX_WIDTH-1:0] idx_q, idx_d;
    logic                     wr_q, wr_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;

    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [WADDR_W-1:0]       addr_q, addr_d;
    logic [BYTES-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

    logic                     ovalid_q, ovalid_d;
    logic [DATA_WIDTH-1:0]    ores_q, ores_d;
    logic [REG_IDX_WIDTH-1:0] oidx_q, oidx_d;
    logic                     owr_q, owr_d;
    logic [PC_WIDTH-1:0]      opc_q, opc_d;
    logic [INSTR_WIDTH-1:0]   oinstr_q, oinstr_d;
    logic                     emis_q, emis_d;
    logic                     eto_q, eto_d;

    logic                     in_load, in_store, in_word, in_misal;
    logic [LANE_BITS-1:0]     in_lane;
    logic [BYTES-1:0]         lane_onehot;
    logic [7:0]               sel_byte;
    logic [DATA_WIDTH-1:0]    load_res;

    assign in_lane = in_addr[LANE_BITS-1:0];

    // Classify the incoming op and build lane-derived helpers.
    always_comb begin
        in_load     = 1'b0;
        in_store    = 1'b0;
        in_word     = 1'b0;
        lane_onehot = '0;
        sel_byte    = '0;
        case (in_op)
            OP_LW:  begin in_load  = 1'b1; in_word = 1'b1; end
            OP_LBS: in_load  = 1'b1;
            OP_LBU: in_load  = 1'b1;
            OP_SW:  begin in_store = 1'b1; in_word = 1'b1; end
            OP_SB:  in_store = 1'b1;
            default: ;
        endcase
        in_misal = in_word && (in_lane != '0);
        for (int i = 0; i < BYTES; i++) begin
            lane_onehot[i] = (in_lane == LANE_BITS'(i));
            if (lane_q == LANE_BITS'(i))
                sel_byte = dmem_rdata[8*i +: 8];
        end
    end

    // Shape the read data according to the captured load type.
    always_comb begin
        case (op_q)
            OP_LW:   load_res = dmem_rdata;
            OP_LBS:  load_res = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            OP_LBU:  load_res = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            default: load_res = res_q;
        endcase
    end

    // Next-state, request and retire logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        lane_d   = lane_q;
        res_d    = res_q;
        idx_d    = idx_q;
        wr_d     = wr_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        ovalid_d = 1'b0;
        ores_d   = ores_q;
        oidx_d   = oidx_q;
        owr_d    = 1'b0;
        opc_d    = opc_q;
        oinstr_d = oinstr_q;
        emis_d   = 1'b0;
        eto_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    lane_d  = in_lane;
                    res_d   = in_res;
                    idx_d   = in_res_reg_idx;
                    wr_d    = in_write_res_to_reg;
                    pc_d    = in_pc;
                    instr_d = in_instr;
                    if ((in_load || in_store) && !in_misal) begin
                        state_d = BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = in_store;
                        addr_d  = in_addr[DMEM_ADDR_WIDTH-1:LANE_BITS];
                        be_d    = in_word ? '1 : lane_onehot;
                        wdata_d = in_word ? in_wr_data
                                          : {BYTES{in_wr_data[7:0]}};
                    end else begin
                        ovalid_d = 1'b1;
                        ores_d   = in_res;
                        oidx_d   = in_res_reg_idx;
                        owr_d    = in_write_res_to_reg && !in_misal;
                        opc_d    = in_pc;
                        oinstr_d = in_instr;
                        emis_d   = in_misal;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    ovalid_d = 1'b1;
                    ores_d   = load_res;
                    oidx_d   = idx_q;
                    owr_d    = wr_q && !(op_q == OP_SW || op_q == OP_SB);
                    opc_d    = pc_q;
                    oinstr_d = instr_q;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    ovalid_d = 1'b1;
                    ores_d   = res_q;
                    oidx_d   = idx_q;
                    opc_d    = pc_q;
                    oinstr_d = instr_q;
                    eto_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            lane_q   <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            ovalid_q <= 1'b0;
            ores_q   <= '0;
            oidx_q   <= '0;
            owr_q    <= 1'b0;
            opc_q    <= '0;
            oinstr_q <= '0;
            emis_q   <= 1'b0;
            eto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            lane_q   <= lane_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            ovalid_q <= ovalid_d;
            ores_q   <= ores_d;
            oidx_q   <= oidx_d;
            owr_q    <= owr_d;
            opc_q    <= opc_d;
            oinstr_q <= oinstr_d;
            emis_q   <= emis_d;
            eto_q    <= eto_d;
        end
    end

    assign out_stall            = (state_q == BUSY);
    assign dmem_req             = req_q;
    assign dmem_we              = we_q;
    assign dmem_addr            = addr_q;
    assign dmem_be              = be_q;
    assign dmem_wdata           = wdata_q;
    assign out_valid            = ovalid_q;
    assign out_res              = ores_q;
    assign out_res_reg_idx      = oidx_q;
    assign out_write_res_to_reg = owr_q;
    assign out_pc               = opc_q;
    assign out_instr            = oinstr_q;
    assign out_exc_misaligned   = emis_q;
    assign out_exc_timeout      = eto_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (MAX_WAIT = 4).
// Inputs change 1 ns after the rising edge; outputs are checked there.
module tb_mem_stage_hs;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [11:0] in_addr;
    logic [15:0] in_wr_data;
    logic [15:0] in_res;
    logic [3:0]  in_res_reg_idx;
    logic        in_write_res_to_reg;
    logic [11:0] in_pc;
    logic [15:0] in_instr;
    logic        out_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [10:0] dmem_addr;
    logic [1:0]  dmem_be;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        out_valid;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic        out_write_res_to_reg;
    logic [11:0] out_pc;
    logic [15:0] out_instr;
    logic        out_exc_misaligned;
    logic        out_exc_timeout;

    int vectors    = 0;
    int miscompares = 0;

    mem_stage_hs #(.MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
        .in_wr_data(in_wr_data), .in_res(in_res),
        .in_res_reg_idx(in_res_reg_idx),
        .in_write_res_to_reg(in_write_res_to_reg),
        .in_pc(in_pc), .in_instr(in_instr),
        .out_stall(out_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_res(out_res),
        .out_res_reg_idx(out_res_reg_idx),
        .out_write_res_to_reg(out_write_res_to_reg),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_exc_misaligned(out_exc_misaligned),
        .out_exc_timeout(out_exc_timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                         input logic [15:0] wd, input logic [15:0] res,
                         input logic [3:0] idx, input logic wr);
        in_valid            = 1'b1;
        in_op               = op;
        in_addr             = addr;
        in_wr_data          = wd;
        in_res              = res;
        in_res_reg_idx      = idx;
        in_write_res_to_reg = wr;
        in_pc               = in_pc + 12'd2;
        in_instr            = in_instr + 16'h0101;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 0; in_op = 0; in_addr = 0; in_wr_data = 0;
        in_res = 0; in_res_reg_idx = 0; in_write_res_to_reg = 0;
        in_pc = 12'h0FE; in_instr = 16'hA0A0;
        dmem_ack = 0; dmem_rdata = 0;
        tick(); tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", out_stall, 0);
        chk("rst_res", out_res, 0);
        reset = 1'b0;
        tick();

        // Non-memory pass-through, latency 1
        issue(3'b000, 12'h000, 16'h0, 16'h1234, 4'd3, 1'b1);
        tick();
        in_valid = 0;
        chk("nm_valid", out_valid, 1);
        chk("nm_res", out_res, 16'h1234);
        chk("nm_idx", out_res_reg_idx, 3);
        chk("nm_wr", out_write_res_to_reg, 1);
        chk("nm_pc", out_pc, 12'h100);
        chk("nm_instr", out_instr, 16'hA1A1);
        chk("nm_req", dmem_req, 0);
        chk("nm_stall", out_stall, 0);
        tick();
        chk("nm_valid_drop", out_valid, 0);
        chk("nm_wr_drop", out_write_res_to_reg, 0);
        chk("nm_res_hold", out_res, 16'h1234);

        // Load byte signed, lane 1, zero wait states
        issue(3'b010, 12'h005, 16'h0, 16'h0000, 4'd5, 1'b1);
        tick();
        in_valid = 0;
        chk("lbs_req", dmem_req, 1);
        chk("lbs_we", dmem_we, 0);
        chk("lbs_addr", dmem_addr, 11'h002);
        chk("lbs_be", dmem_be, 2'b10);
        chk("lbs_stall", out_stall, 1);
        chk("lbs_valid_busy", out_valid, 0);
        dmem_ack = 1; dmem_rdata = 16'h8A7F;
        tick();
        dmem_ack = 0;
        chk("lbs_valid", out_valid, 1);
        chk("lbs_res", out_res, 16'hFF8A);
        chk("lbs_idx", out_res_reg_idx, 5);
        chk("lbs_wr", out_write_res_to_reg, 1);
        chk("lbs_req_drop", dmem_req, 0);
        chk("lbs_stall_drop", out_stall, 0);

        // Load byte unsigned, lane 0, accepted while out_valid high
        issue(3'b011, 12'h004, 16'h0, 16'h0000, 4'd6, 1'b1);
        tick();
        in_valid = 0;
        chk("lbu_be", dmem_be, 2'b01);
        dmem_ack = 1; dmem_rdata = 16'h12F0;
        tick();
        dmem_ack = 0;
        chk("lbu_res", out_res, 16'h00F0);
        chk("lbu_valid", out_valid, 1);

        // Store byte with 3 wait states; ack lands on the timeout cycle
        issue(3'b101, 12'h004, 16'h00C3, 16'h5555, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            in_valid = 0;
            chk("sb_req", dmem_req, 1);
            chk("sb_we", dmem_we, 1);
            chk("sb_be", dmem_be, 2'b01);
            chk("sb_wdata", dmem_wdata, 16'hC3C3);
            chk("sb_addr", dmem_addr, 11'h002);
            chk("sb_valid_busy", out_valid, 0);
        end
        dmem_ack = 1;
        tick();
        dmem_ack = 0;
        chk("sb_valid", out_valid, 1);
        chk("sb_wr", out_write_res_to_reg, 0);
        chk("sb_res", out_res, 16'h5555);
        chk("sb_to", out_exc_timeout, 0);
        chk("sb_req_drop", dmem_req, 0);

        // Misaligned load word
        issue(3'b001, 12'h003, 16'h0, 16'h7777, 4'd4, 1'b1);
        tick();
        in_valid = 0;
        chk("mis_req", dmem_req, 0);
        chk("mis_valid", out_valid, 1);
        chk("mis_exc", out_exc_misaligned, 1);
        chk("mis_wr", out_write_res_to_reg, 0);
        chk("mis_res", out_res, 16'h7777);
        tick();
        chk("mis_exc_drop", out_exc_misaligned, 0);

        // Timeout: 4 BUSY cycles, no ack
        issue(3'b001, 12'h020, 16'h0, 16'h0000, 4'd8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            in_valid = 0;
            chk("to_req", dmem_req, 1);
            chk("to_stall", out_stall, 1);
        end
        tick();
        chk("to_req_drop", dmem_req, 0);
        chk("to_valid", out_valid, 1);
        chk("to_exc", out_exc_timeout, 1);
        chk("to_wr", out_write_res_to_reg, 0);
        dmem_ack = 1; dmem_rdata = 16'hDEAD;
        tick();
        dmem_ack = 0;
        chk("late_ack_valid", out_valid, 0);
        chk("late_ack_req", dmem_req, 0);
        chk("late_ack_exc", out_exc_timeout, 0);
        issue(3'b110, 12'h000, 16'h0, 16'h0042, 4'd7, 1'b1);
        tick();
        in_valid = 0;
        chk("post_to_valid", out_valid, 1);
        chk("post_to_res", out_res, 16'h0042);
        chk("post_to_wr", out_write_res_to_reg, 1);
        chk("post_to_idx", out_res_reg_idx, 7);

        // Reset in BUSY
        issue(3'b001, 12'h010, 16'h0, 16'h0000, 4'd9, 1'b1);
        tick();
        in_valid = 0;
        chk("rb_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        chk("rb_req_drop", dmem_req, 0);
        chk("rb_stall", out_stall, 0);
        chk("rb_res", out_res, 0);
        chk("rb_pc", out_pc, 0);
        chk("rb_be", dmem_be, 0);
        tick();
        reset = 1'b0;
        dmem_ack = 1; dmem_rdata = 16'h1111;
        tick();
        dmem_ack = 0;
        chk("rb_ack_ignored", out_valid, 0);
        issue(3'b001, 12'h010, 16'h0, 16'h0000, 4'd10, 1'b1);
        tick();
        in_valid = 0;
        chk("rb_lw_addr", dmem_addr, 11'h008);
        chk("rb_lw_be", dmem_be, 2'b11);
        dmem_ack = 1; dmem_rdata = 16'hBEEF;
        tick();
        dmem_ack = 0;
        chk("rb_lw_valid", out_valid, 1);
        chk("rb_lw_res", out_res, 16'hBEEF);
        chk("rb_lw_idx", out_res_reg_idx, 10);
        chk("rb_lw_wr", out_write_res_to_reg, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Memory (MEM) pipeline stage for the 16-bit core. Replaces the single-cycle, always-ready data-memory access with a request/acknowledge handshake to a variable-latency DMEM.
- Generalised data width, byte-lane select and byte-enable stores, sign extension taken from the selected byte, misalignment and timeout exceptions, and a stall output back to EX.
- Sits between EX and WB; drives the DMEM port directly.

Parameters:
- DMEM_ADDR_WIDTH, 12, byte-address width of in_addr.
- DATA_WIDTH, 16, data word width. Must be a multiple of 8 and at least 16. BYTES = DATA_WIDTH/8; LANE_BITS = clog2(BYTES).
- REG_IDX_WIDTH, 4, register index width.
- PC_WIDTH, 12, program counter width.
- INSTR_WIDTH, 16, instruction word width.
- MAX_WAIT, 15, number of BUSY cycles without ack before timeout (at least 1).

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX presents an instruction.
- in_op  in  3  000 none, 001 load word, 010 load byte signed, 011 load byte unsigned, 100 store word, 101 store byte. 110/111 behave as none.
- in_addr  in  DMEM_ADDR_WIDTH  byte address.
- in_wr_data  in  DATA_WIDTH  store data; byte stores use bits [7:0].
- in_res  in  DATA_WIDTH  ALU result for non-load ops.
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register.
- in_write_res_to_reg  in  1  writeback request.
- in_pc  in  PC_WIDTH  pass-through.
- in_instr  in  INSTR_WIDTH  pass-through.
- out_stall  out  1  EX must hold its inputs.
- dmem_req  out  1  access request, registered.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DMEM_ADDR_WIDTH-LANE_BITS  word address = in_addr upper bits.
- dmem_be  out  BYTES  byte enables.
- dmem_wdata  out  DATA_WIDTH  write data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_WIDTH  read data.
- out_valid  out  1  one-cycle pulse per retired instruction.
- out_res  out  DATA_WIDTH  result to WB.
- out_res_reg_idx  out  REG_IDX_WIDTH  destination register.
- out_write_res_to_reg  out  1  writeback enable.
- out_pc  out  PC_WIDTH  PC of the retired instruction.
- out_instr  out  INSTR_WIDTH  instruction word of the retired instruction.
- out_exc_misaligned  out  1  misaligned word access.
- out_exc_timeout  out  1  DMEM did not acknowledge.

Behaviour:
- Reset:
  - State IDLE, wait counter 0.
  - Every output register is 0; dmem_req drops immediately on reset assertion.
  - Reset during BUSY abandons the access; a later dmem_ack is ignored.
- Combinational: out_stall = (state == BUSY).
- IDLE, accept condition is in_valid=1. At the clock edge, capture op, addr, lane, wr_data, res, reg_idx, write flag, pc and instr.
- IDLE, accepted non-memory op (none or reserved):
  - Next cycle out_valid=1; out_res=in_res; other fields are the captured values. Latency is 1.
- IDLE, accepted word op with in_addr[LANE_BITS-1:0] != 0:
  - No request is issued.
  - Next cycle out_valid=1, out_exc_misaligned=1, out_write_res_to_reg=0, out_res=in_res.
- IDLE, accepted aligned memory op: go to BUSY.
  - dmem_req=1 from the next cycle.
  - dmem_we=1 for stores, 0 for loads.
  - dmem_be: all ones for word ops; one-hot at the lane for byte ops. Loads drive the same enables.
  - dmem_wdata: in_wr_data for store word; in_wr_data[7:0] replicated to every lane for store byte.
- BUSY: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable. The wait counter increments each cycle without ack.
- BUSY, dmem_ack=1: go to IDLE.
  - dmem_req=0 next cycle; out_valid=1 next cycle.
  - Load word: out_res=dmem_rdata.
  - Load byte: out_res[7:0] = selected lane byte. Upper bits are that byte's bit 7 replicated (signed) or 0 (unsigned).
  - Stores: out_res=captured res, out_write_res_to_reg forced 0.
  - Zero-wait-state access has latency 2.
- BUSY, counter reaches MAX_WAIT-1 with no ack: go to IDLE and drop req.
  - Next cycle out_valid=1, out_exc_timeout=1, out_write_res_to_reg=0.
- Ack and timeout in the same cycle: the ack wins and the instruction completes normally.
- dmem_ack in IDLE: ignored.
- in_valid while BUSY: ignored; EX holds its inputs.
- Cycles in which out_valid=0: out_write_res_to_reg and both exception flags are 0. Other data outputs hold their last values.
- A new instruction can be accepted in the same cycle that out_valid is high.

Test Plan:
- Non-memory pass-through: in_op=000, in_res=0x1234, idx=3, write=1 -> one cycle later out_valid=1, out_res=0x1234, idx=3, write=1; dmem_req stays 0.
- Load byte signed, zero wait states: addr=0x005, ack the cycle after accept with rdata=0x8A7F. Required: dmem_addr=0x002, be=2'b10, out_res=0xFF8A, out_valid two cycles after accept, out_stall high for one cycle.
- Store byte with 3 wait states: addr=0x004, wr_data=0x00C3. Required: req held 4 cycles with be=2'b01 and wdata=0xC3C3; on completion out_valid=1 and out_write_res_to_reg=0.
- Misaligned load word at addr=0x003 -> no dmem_req; next cycle out_exc_misaligned=1, write=0.
- Timeout with MAX_WAIT=4: no ack -> req drops after 4 BUSY cycles and out_exc_timeout=1. A later ack is ignored, and a following non-memory op retires normally.
- Reset asserted during BUSY -> dmem_req=0 immediately and all outputs 0; after release, a load word at 0x010 with ack rdata=0xBEEF retires with out_res=0xBEEF.
